// File: rtl/rotary_encoder_emulator.sv
// CPU-driven rotary-encoder waveform generator: plays N quadrature detents in a chosen direction,
// optionally holding the push switch, then leaves a quiet gap before signalling completion.
module rotary_encoder_emulator #(
    parameter int unsigned STEP_DIV = 4096,
    parameter int unsigned SW_HOLD  = 65536
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_wr_stb,
    input  logic [7:0]  cmd_data,
    input  logic        status_rd_stb,
    output logic [7:0]  status_reg,
    output logic        busy,
    output logic        done_stb,
    output logic        encoder_A,
    output logic        encoder_B,
    output logic        encoder_sw,
    output logic [15:0] test
);

    localparam int unsigned SETTLE_CYC = 4 * STEP_DIV;
    localparam int unsigned SETTLE_W   = $clog2(SETTLE_CYC);
    localparam int unsigned HOLD_W     = $clog2(SW_HOLD + 1);
    localparam int unsigned TMR_W      = (SETTLE_W > HOLD_W) ? SETTLE_W : HOLD_W;

    localparam logic [TMR_W-1:0] PH_LAST     = TMR_W'(STEP_DIV - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(SW_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESS   = 3'd1,
        S_ROTATE  = 3'd2,
        S_RELEASE = 3'd3,
        S_SETTLE  = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [1:0]         ab_q, ab_d;
    logic               dir_q, dir_d;
    logic               press_q, press_d;
    logic               rej_q, rej_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sw_q, sw_d;
    logic [1:0]         ab_next;
    logic               hold;

    // Next quadrature phase, {B,A}: cw 00->01->11->10, ccw 00->10->11->01
    always_comb begin
        ab_next = 2'b00;
        unique case ({dir_q, ab_q})
            3'b1_00: ab_next = 2'b01;
            3'b1_01: ab_next = 2'b11;
            3'b1_11: ab_next = 2'b10;
            3'b1_10: ab_next = 2'b00;
            3'b0_00: ab_next = 2'b10;
            3'b0_10: ab_next = 2'b11;
            3'b0_11: ab_next = 2'b01;
            3'b0_01: ab_next = 2'b00;
            default: ab_next = 2'b00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + TMR_W'(1);
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        dir_d   = dir_q;
        press_d = press_q;
        hold    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (cmd_wr_stb) begin
                    dir_d   = cmd_data[0];
                    press_d = cmd_data[1];
                    cnt_d   = cmd_data[7:2];
                    if (cmd_data[1])                 state_d = S_PRESS;
                    else if (cmd_data[7:2] != 6'd0)  state_d = S_ROTATE;
                    else                             state_d = S_SETTLE;
                end
            end
            S_PRESS: begin
                if (tmr_q == HOLD_LAST) begin
                    tmr_d   = '0;
                    state_d = (cnt_q != 6'd0) ? S_ROTATE : S_RELEASE;
                end
            end
            S_ROTATE: begin
                if (tmr_q == PH_LAST) begin
                    tmr_d = '0;
                    ab_d  = ab_next;
                    if (ab_next == 2'b00) begin
                        cnt_d = cnt_q - 6'd1;
                        if (cnt_q == 6'd1) state_d = press_q ? S_RELEASE : S_SETTLE;
                    end
                end
            end
            S_RELEASE: begin
                tmr_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // A reject in the same cycle as a status read keeps the sticky bit set
        if (cmd_wr_stb && (state_q != S_IDLE)) rej_d = 1'b1;
        else if (status_rd_stb)                rej_d = 1'b0;
        else                                   rej_d = rej_q;

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);

        // Switch stays held through the cycle the final 00 appears, released one cycle later
        hold = press_d && ((state_d == S_PRESS) || (state_d == S_ROTATE) || (state_q == S_ROTATE));
        sw_d = ~hold;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cnt_q   <= 6'd0;
            ab_q    <= 2'b00;
            dir_q   <= 1'b0;
            press_q <= 1'b0;
            rej_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sw_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            dir_q   <= dir_d;
            press_q <= press_d;
            rej_q   <= rej_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sw_q    <= sw_d;
        end
    end

    assign encoder_A  = ab_q[0];
    assign encoder_B  = ab_q[1];
    assign encoder_sw = sw_q;
    assign busy       = busy_q;
    assign done_stb   = done_q;
    assign status_reg = {4'b0000, rej_q, press_q, dir_q, busy_q};
    assign test       = {4'b0000, rej_q, cnt_q, ab_q, state_q};

endmodule
